// File: rtl/cajero_param.sv
// cajero_param -- ATM session controller.
//
// Accepts a card session, collects a BCD PIN one digit at a time, verifies it
// against the stored PIN with a persistent failed-attempt counter and lockout,
// then serves deposits and withdrawals against a local copy of the account
// balance, enforcing insufficient-funds and a per-session withdrawal limit.
//
// Ports
//   CLK                  in   clock, rising edge
//   RESET                in   synchronous, active-low reset
//   TARJETA_RECIBIDA     in   card present (level); session lasts while high
//   PIN_CORRECTO         in   stored PIN, first digit in the top nibble
//   DIGITO / DIGITO_STB  in   entered digit and its one-cycle strobe
//   TIPO_TRANS           in   0 = deposit, 1 = withdrawal
//   MONTO / MONTO_STB    in   amount and its one-cycle strobe
//   BALANCE_INICIAL      in   balance loaded at session start
//   BALANCE_ACTUALIZADO  out  current balance register
//   BALANCE_STB          out  pulse, balance changed
//   ENTREGAR_DINERO      out  pulse, dispense cash
//   FONDOS_INSUFICIENTES out  pulse, withdrawal larger than balance
//   LIMITE_EXCEDIDO      out  pulse, session withdrawal limit would be exceeded
//   PIN_INCORRECTO       out  pulse, PIN mismatch
//   ADVERTENCIA          out  level, one attempt left before lockout
//   BLOQUEO              out  level, card locked until reset
//
// state       | meaning
// ESPERA      | idle, waiting for a card
// PIN         | collecting PIN digits
// VERIFICA    | comparing the collected PIN with the stored one
// TRANSACCION | PIN accepted, serving deposits/withdrawals
// BLOQUEADO   | too many failed attempts, everything ignored until reset

module cajero_param #(
  parameter int PIN_DIGITS    = 4,
  parameter int MAX_INTENTOS  = 3,
  parameter int BAL_W         = 64,
  parameter int MONTO_W       = 32,
  parameter int LIMITE_SESION = 1000
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    TARJETA_RECIBIDA,
  input  logic [4*PIN_DIGITS-1:0] PIN_CORRECTO,
  input  logic [3:0]              DIGITO,
  input  logic                    DIGITO_STB,
  input  logic                    TIPO_TRANS,
  input  logic [MONTO_W-1:0]      MONTO,
  input  logic                    MONTO_STB,
  input  logic [BAL_W-1:0]        BALANCE_INICIAL,
  output logic [BAL_W-1:0]        BALANCE_ACTUALIZADO,
  output logic                    BALANCE_STB,
  output logic                    ENTREGAR_DINERO,
  output logic                    FONDOS_INSUFICIENTES,
  output logic                    LIMITE_EXCEDIDO,
  output logic                    PIN_INCORRECTO,
  output logic                    ADVERTENCIA,
  output logic                    BLOQUEO
);

  localparam logic [2:0] ESPERA      = 3'd0;
  localparam logic [2:0] PIN         = 3'd1;
  localparam logic [2:0] VERIFICA    = 3'd2;
  localparam logic [2:0] TRANSACCION = 3'd3;
  localparam logic [2:0] BLOQUEADO   = 3'd4;

  localparam int PIN_W = 4 * PIN_DIGITS;
  localparam int CNT_W = $clog2(PIN_DIGITS + 1);
  localparam int INT_W = $clog2(MAX_INTENTOS + 1);
  // The accumulator never exceeds the limit, but it must also hold any single
  // amount plus one bit so that accumulator + MONTO is compared without wrap.
  localparam int LIM_W = $clog2(LIMITE_SESION + 1);
  localparam int ACC_W = (MONTO_W + 1 > LIM_W) ? MONTO_W + 1 : LIM_W;
  localparam logic [ACC_W:0] LIMITE_EXT = (ACC_W + 1)'(LIMITE_SESION);

  logic [2:0]       state_q, state_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic [ACC_W-1:0] acum_q, acum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PIN_W-1:0] pin_q, pin_d;
  logic [INT_W-1:0] int_q, int_d;
  logic             bal_stb_q, bal_stb_d;
  logic             entregar_q, entregar_d;
  logic             fondos_q, fondos_d;
  logic             limite_q, limite_d;
  logic             pin_inc_q, pin_inc_d;
  logic             adv_q, adv_d;
  logic             bloq_q, bloq_d;

  logic [BAL_W-1:0] monto_bal;
  logic [BAL_W:0]   dep_sum;
  logic [ACC_W:0]   acc_sum;
  logic [INT_W-1:0] int_inc;

  assign monto_bal = BAL_W'(MONTO);
  assign dep_sum   = {1'b0, bal_q} + {1'b0, monto_bal};
  assign acc_sum   = {1'b0, acum_q} + (ACC_W + 1)'(MONTO);
  assign int_inc   = int_q + INT_W'(1);

  always_comb begin
    state_d    = state_q;
    bal_d      = bal_q;
    acum_d     = acum_q;
    cnt_d      = cnt_q;
    pin_d      = pin_q;
    int_d      = int_q;
    adv_d      = adv_q;
    bloq_d     = bloq_q;
    bal_stb_d  = 1'b0;
    entregar_d = 1'b0;
    fondos_d   = 1'b0;
    limite_d   = 1'b0;
    pin_inc_d  = 1'b0;

    case (state_q)
      ESPERA: begin
        if (TARJETA_RECIBIDA) begin
          bal_d   = BALANCE_INICIAL;
          cnt_d   = '0;
          pin_d   = '0;
          acum_d  = '0;
          state_d = PIN;
        end
      end

      PIN: begin
        if (!TARJETA_RECIBIDA) begin
          state_d = ESPERA;
        end else if (DIGITO_STB) begin
          pin_d = (pin_q << 4) | PIN_W'(DIGITO);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(PIN_DIGITS - 1)) state_d = VERIFICA;
        end
      end

      VERIFICA: begin
        if (!TARJETA_RECIBIDA) begin
          state_d = ESPERA;
        end else if (pin_q == PIN_CORRECTO) begin
          int_d   = '0;
          adv_d   = 1'b0;
          state_d = TRANSACCION;
        end else begin
          int_d     = int_inc;
          pin_inc_d = 1'b1;
          cnt_d     = '0;
          if (int_inc == INT_W'(MAX_INTENTOS)) begin
            bloq_d  = 1'b1;
            state_d = BLOQUEADO;
          end else begin
            if (int_inc == INT_W'(MAX_INTENTOS - 1)) adv_d = 1'b1;
            state_d = PIN;
          end
        end
      end

      TRANSACCION: begin
        if (!TARJETA_RECIBIDA) begin
          state_d = ESPERA;
        end else if (MONTO_STB) begin
          if (!TIPO_TRANS) begin
            // A carry out of the add means the true sum no longer fits.
            bal_d     = dep_sum[BAL_W] ? '1 : dep_sum[BAL_W-1:0];
            bal_stb_d = 1'b1;
          end else if (monto_bal > bal_q) begin
            fondos_d = 1'b1;
          end else if (acc_sum > LIMITE_EXT) begin
            limite_d = 1'b1;
          end else begin
            bal_d      = bal_q - monto_bal;
            acum_d     = acc_sum[ACC_W-1:0];
            bal_stb_d  = 1'b1;
            entregar_d = 1'b1;
          end
        end
      end

      BLOQUEADO: begin
        state_d = BLOQUEADO;
      end

      default: begin
        state_d = ESPERA;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= ESPERA;
      bal_q      <= '0;
      acum_q     <= '0;
      cnt_q      <= '0;
      pin_q      <= '0;
      int_q      <= '0;
      adv_q      <= 1'b0;
      bloq_q     <= 1'b0;
      bal_stb_q  <= 1'b0;
      entregar_q <= 1'b0;
      fondos_q   <= 1'b0;
      limite_q   <= 1'b0;
      pin_inc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bal_q      <= bal_d;
      acum_q     <= acum_d;
      cnt_q      <= cnt_d;
      pin_q      <= pin_d;
      int_q      <= int_d;
      adv_q      <= adv_d;
      bloq_q     <= bloq_d;
      bal_stb_q  <= bal_stb_d;
      entregar_q <= entregar_d;
      fondos_q   <= fondos_d;
      limite_q   <= limite_d;
      pin_inc_q  <= pin_inc_d;
    end
  end

  assign BALANCE_ACTUALIZADO  = bal_q;
  assign BALANCE_STB          = bal_stb_q;
  assign ENTREGAR_DINERO      = entregar_q;
  assign FONDOS_INSUFICIENTES = fondos_q;
  assign LIMITE_EXCEDIDO      = limite_q;
  assign PIN_INCORRECTO       = pin_inc_q;
  assign ADVERTENCIA          = adv_q;
  assign BLOQUEO              = bloq_q;

endmodule

// File: tb/tb_cajero_param.sv
// Bench for cajero_param: a default-parameter instance for the main checks and
// an 8-bit-balance instance, sharing the same stimulus, for saturation.
module tb_cajero_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tarjeta = 1'b0;
  logic [15:0] pin_ok = 16'h1234;
  logic [3:0]  digito = 4'd0;
  logic        dstb = 1'b0;
  logic        tipo = 1'b0;
  logic [31:0] monto = 32'd0;
  logic        mstb = 1'b0;
  logic [63:0] bal_ini = 64'd0;

  logic [63:0] bal;
  logic        stb, ent, fon, lim, pinc, adv, blq;
  logic [7:0]  s_bal;
  logic        s_stb, s_ent, s_fon, s_lim, s_pinc, s_adv, s_blq;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  cajero_param dut (
    .CLK(clk), .RESET(rst_n), .TARJETA_RECIBIDA(tarjeta), .PIN_CORRECTO(pin_ok),
    .DIGITO(digito), .DIGITO_STB(dstb), .TIPO_TRANS(tipo), .MONTO(monto),
    .MONTO_STB(mstb), .BALANCE_INICIAL(bal_ini),
    .BALANCE_ACTUALIZADO(bal), .BALANCE_STB(stb), .ENTREGAR_DINERO(ent),
    .FONDOS_INSUFICIENTES(fon), .LIMITE_EXCEDIDO(lim), .PIN_INCORRECTO(pinc),
    .ADVERTENCIA(adv), .BLOQUEO(blq)
  );

  cajero_param #(.BAL_W(8), .MONTO_W(8)) dut8 (
    .CLK(clk), .RESET(rst_n), .TARJETA_RECIBIDA(tarjeta), .PIN_CORRECTO(pin_ok),
    .DIGITO(digito), .DIGITO_STB(dstb), .TIPO_TRANS(tipo), .MONTO(monto[7:0]),
    .MONTO_STB(mstb), .BALANCE_INICIAL(bal_ini[7:0]),
    .BALANCE_ACTUALIZADO(s_bal), .BALANCE_STB(s_stb), .ENTREGAR_DINERO(s_ent),
    .FONDOS_INSUFICIENTES(s_fon), .LIMITE_EXCEDIDO(s_lim), .PIN_INCORRECTO(s_pinc),
    .ADVERTENCIA(s_adv), .BLOQUEO(s_blq)
  );

  typedef struct {
    logic        new_sess;
    logic [63:0] bal_ini;
    logic        tipo;
    logic [31:0] monto;
    logic [63:0] exp_bal;
    logic        exp_stb;
    logic        exp_ent;
    logic        exp_fon;
    logic        exp_lim;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tarjeta = 1'b0; dstb = 1'b0; mstb = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic start_session(input logic [63:0] b);
    bal_ini = b;
    tarjeta = 1'b1;
    tick();
  endtask

  task automatic end_session();
    tarjeta = 1'b0;
    tick();
  endtask

  // Four back-to-back digit strobes, then one cycle for the compare.
  task automatic enter_pin(input logic [15:0] p);
    for (int k = 0; k < 4; k++) begin
      digito = p[15-4*k -: 4];
      dstb = 1'b1;
      tick();
    end
    dstb = 1'b0;
    tick();
  endtask

  task automatic do_trans(input logic t, input logic [31:0] m);
    tipo = t;
    monto = m;
    mstb = 1'b1;
    tick();
    mstb = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chkw({tag, " bal"}, bal, 64'd0);
    chk1({tag, " stb"}, stb, 1'b0);
    chk1({tag, " ent"}, ent, 1'b0);
    chk1({tag, " fon"}, fon, 1'b0);
    chk1({tag, " lim"}, lim, 1'b0);
    chk1({tag, " pinc"}, pinc, 1'b0);
    chk1({tag, " adv"}, adv, 1'b0);
    chk1({tag, " blq"}, blq, 1'b0);
  endtask

  initial begin
    //         new   bal_ini     tipo  monto            exp_bal             stb ent fon lim
    vecs[0]  = '{1'b1, 64'd5000, 1'b1, 32'd300,        64'd4700,           1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 64'd5000, 1'b1, 32'd600,        64'd4400,           1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 64'd0,    1'b1, 32'd500,        64'd4400,           1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 64'd0,    1'b1, 32'd400,        64'd4000,           1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 64'd0,    1'b1, 32'd1,          64'd4000,           1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 64'd0,    1'b1, 32'd5000,       64'd4000,           1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 64'd0,    1'b0, 32'd250,        64'd4250,           1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 64'd200,  1'b1, 32'd500,        64'd200,            1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 64'd0,    1'b0, 32'd100,        64'd300,            1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 64'd0,    1'b1, 32'd300,        64'd0,              1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 64'd0,    1'b1, 32'd1,          64'd0,              1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 64'd2000, 1'b1, 32'd1000,       64'd1000,           1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 64'd0,    1'b0, 32'hFFFF_FFFF,  64'd4294968295,     1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Transaction table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].new_sess) begin
        end_session();
        start_session(vecs[i].bal_ini);
        enter_pin(16'h1234);
      end
      do_trans(vecs[i].tipo, vecs[i].monto);
      chkw($sformatf("v%0d bal", i), bal, vecs[i].exp_bal);
      chk1($sformatf("v%0d stb", i), stb, vecs[i].exp_stb);
      chk1($sformatf("v%0d ent", i), ent, vecs[i].exp_ent);
      chk1($sformatf("v%0d fon", i), fon, vecs[i].exp_fon);
      chk1($sformatf("v%0d lim", i), lim, vecs[i].exp_lim);
      tick();
      chk1($sformatf("v%0d pulse end", i), stb | ent | fon | lim, 1'b0);
    end

    // Three wrong PINs -> warning then lockout held through card removal
    do_reset();
    start_session(64'd5000);
    enter_pin(16'h1235);
    chk1("wrong1 pinc", pinc, 1'b1);
    chk1("wrong1 adv", adv, 1'b0);
    tick();
    chk1("wrong1 pinc end", pinc, 1'b0);
    enter_pin(16'h1235);
    chk1("wrong2 pinc", pinc, 1'b1);
    chk1("wrong2 adv", adv, 1'b1);
    chk1("wrong2 blq", blq, 1'b0);
    enter_pin(16'h1235);
    chk1("wrong3 pinc", pinc, 1'b1);
    chk1("wrong3 blq", blq, 1'b1);
    end_session();
    tick();
    tick();
    chk1("locked no card", blq, 1'b1);
    start_session(64'd5000);
    enter_pin(16'h1234);
    do_trans(1'b1, 32'd100);
    chk1("locked blq", blq, 1'b1);
    chk1("locked no stb", stb, 1'b0);
    chkw("locked bal", bal, 64'd5000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk1("unlock blq", blq, 1'b0);
    chkw("unlock bal", bal, 64'd0);

    // Attempt count persists across card removal; clears on correct PIN
    do_reset();
    start_session(64'd5000);
    enter_pin(16'h1235);
    chk1("persist pinc", pinc, 1'b1);
    end_session();
    start_session(64'd5000);
    do_trans(1'b0, 32'd777);
    chk1("monto in PIN stb", stb, 1'b0);
    chkw("monto in PIN bal", bal, 64'd5000);
    enter_pin(16'h1235);
    chk1("persist adv", adv, 1'b1);
    chk1("persist blq", blq, 1'b0);
    enter_pin(16'h1234);
    chk1("correct adv clr", adv, 1'b0);
    chk1("correct pinc", pinc, 1'b0);
    // Deposit strobe coincident with card removal is dropped
    tipo = 1'b0; monto = 32'd500; mstb = 1'b1; tarjeta = 1'b0;
    tick();
    mstb = 1'b0;
    chk1("removal stb", stb, 1'b0);
    chkw("removal bal", bal, 64'd5000);
    start_session(64'd5000);
    enter_pin(16'h1235);
    chk1("count cleared adv", adv, 1'b0);
    enter_pin(16'h1234);
    do_trans(1'b1, 32'd100);
    chkw("pre-reset bal", bal, 64'd4900);
    // Reset coinciding with a withdrawal strobe wins
    rst_n = 1'b0; tipo = 1'b1; monto = 32'd100; mstb = 1'b1;
    tick();
    mstb = 1'b0; rst_n = 1'b1;
    chk_all_zero("rst mid");

    // 8-bit balance saturates on deposit
    do_reset();
    start_session(64'd250);
    enter_pin(16'h1234);
    do_trans(1'b0, 32'd10);
    chkw("sat bal", 64'(s_bal), 64'd255);
    chk1("sat stb", s_stb, 1'b1);
    chk1("sat quiet", s_ent | s_fon | s_lim | s_pinc | s_adv | s_blq, 1'b0);
    chkw("wide bal", bal, 64'd260);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
